// File: rtl/tmds_pll_sequencer.sv
`default_nettype none
// tmds_pll_sequencer: PLL reset/lock sequencing, retry/fail handling and video mode select.
// Rev 1.0
module tmds_pll_sequencer #(
  parameter int NUM_MODES    = 4,
  parameter int DEFAULT_MODE = 0,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8,
  localparam int MODE_W      = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              req_valid,
  input  logic [MODE_W-1:0] req_mode,
  output logic              req_ready,
  output logic [MODE_W-1:0] mode_sel,
  output logic              mode_err,
  output logic              pll_reset,
  output logic              pll_pwd,
  output logic              video_rst_n,
  output logic              ready,
  output logic              fail,
  output logic [3:0]        retry_cnt,
  output logic [CNT_W-1:0]  lock_loss_cnt
);

  localparam int RW = $clog2(RST_CYCLES);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RW-1:0]     RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0]     STABLE_END  = SW'(LOCK_STABLE);
  localparam logic [TW-1:0]     TIMEOUT_END = TW'(LOCK_TIMEOUT);
  localparam logic [3:0]        RETRY_LAST  = 4'(MAX_RETRY);
  localparam logic [MODE_W-1:0] MODE_INIT   = MODE_W'(DEFAULT_MODE);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_FAIL      = 2'd3
  } state_t;

  state_t         state;
  logic           lock_m;
  logic           lock_s;
  logic           dip;
  logic [RW-1:0]  rst_cnt;
  logic [SW-1:0]  stable_cnt;
  logic [TW-1:0]  timeout_cnt;

  logic mode_ok;
  logic accept;
  logic take;
  logic loss;
  logic stable_done;
  logic timeout_done;
  logic retry_now;
  logic fail_now;
  logic restart;

  // Range check collapses to a constant when every encoding is a legal mode.
  if (NUM_MODES == (1 << MODE_W)) begin : g_full_range
    assign mode_ok = 1'b1;
  end else begin : g_part_range
    assign mode_ok = (req_mode < MODE_W'(NUM_MODES));
  end

  always_comb begin
    accept       = req_valid && req_ready;
    take         = accept && mode_ok;
    loss         = (state == S_RUN) && !lock_s && dip;
    stable_done  = (state == S_WAIT_LOCK) && (stable_cnt == STABLE_END);
    timeout_done = (state == S_WAIT_LOCK) && !stable_done && (timeout_cnt == TIMEOUT_END);
    retry_now    = timeout_done && (retry_cnt != RETRY_LAST);
    fail_now     = timeout_done && (retry_cnt == RETRY_LAST);
    restart      = take || loss || retry_now;
  end

  // Counters are compared as registered values, so ready rises on the
  // (RST_CYCLES + 1 + LOCK_STABLE)-th edge after reset release when lock is
  // already high; the synchroniser latency is hidden under the reset pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_RESET;
      lock_m        <= 1'b0;
      lock_s        <= 1'b0;
      dip           <= 1'b0;
      rst_cnt       <= '0;
      stable_cnt    <= '0;
      timeout_cnt   <= '0;
      req_ready     <= 1'b0;
      mode_sel      <= MODE_INIT;
      mode_err      <= 1'b0;
      pll_reset     <= 1'b1;
      pll_pwd       <= 1'b0;
      video_rst_n   <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= '0;
    end else begin
      lock_m   <= pll_lock;
      lock_s   <= lock_m;
      mode_err <= accept && !mode_ok;

      if (loss && (lock_loss_cnt != {CNT_W{1'b1}})) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end

      if (restart) begin
        state       <= S_RESET;
        rst_cnt     <= '0;
        dip         <= 1'b0;
        pll_reset   <= 1'b1;
        pll_pwd     <= 1'b0;
        ready       <= 1'b0;
        video_rst_n <= 1'b0;
        fail        <= 1'b0;
        req_ready   <= 1'b0;
        retry_cnt   <= retry_now ? retry_cnt + 4'd1 : 4'd0;
        if (take) begin
          mode_sel <= req_mode;
        end
      end else begin
        case (state)
          S_RESET: begin
            if (rst_cnt == RST_LAST) begin
              state       <= S_WAIT_LOCK;
              pll_reset   <= 1'b0;
              stable_cnt  <= '0;
              timeout_cnt <= '0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (stable_done) begin
              state       <= S_RUN;
              ready       <= 1'b1;
              video_rst_n <= 1'b1;
              req_ready   <= 1'b1;
              dip         <= 1'b0;
            end else if (fail_now) begin
              state     <= S_FAIL;
              fail      <= 1'b1;
              pll_pwd   <= 1'b1;
              req_ready <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
              stable_cnt  <= lock_s ? stable_cnt + 1'b1 : '0;
            end
          end
          S_RUN: begin
            dip <= !lock_s;
          end
          S_FAIL: begin
            state <= S_FAIL;
          end
          default: begin
            state <= S_RESET;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_pll_sequencer.sv
`default_nettype none
// Bench for tmds_pll_sequencer: directed vector table, mode-error sequence, random run vs. reference model.
module tb_tmds_pll_sequencer;

  localparam int RSTC = 4;
  localparam int LS   = 8;
  localparam int LT   = 32;
  localparam int MR   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic       req_ready, mode_err, pll_reset, pll_pwd, video_rst_n, ready, fail;
  logic [1:0] mode_sel;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  logic       req_valid2 = 1'b0;
  logic [2:0] req_mode2 = 3'd0;
  logic       b_req_ready, b_mode_err, b_pll_reset, b_pll_pwd, b_video_rst_n, b_ready, b_fail;
  logic [2:0] b_mode_sel;
  logic [3:0] b_retry_cnt;
  logic [7:0] b_lock_loss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tmds_pll_sequencer #(
    .NUM_MODES(4), .DEFAULT_MODE(0), .RST_CYCLES(RSTC), .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .req_valid(req_valid),
    .req_mode(req_mode), .req_ready(req_ready), .mode_sel(mode_sel),
    .mode_err(mode_err), .pll_reset(pll_reset), .pll_pwd(pll_pwd),
    .video_rst_n(video_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  // Non-power-of-two mode count so that out-of-range requests are encodable.
  tmds_pll_sequencer #(
    .NUM_MODES(5), .DEFAULT_MODE(0), .RST_CYCLES(RSTC), .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .CNT_W(8)
  ) dut5 (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .req_valid(req_valid2),
    .req_mode(req_mode2), .req_ready(b_req_ready), .mode_sel(b_mode_sel),
    .mode_err(b_mode_err), .pll_reset(b_pll_reset), .pll_pwd(b_pll_pwd),
    .video_rst_n(b_video_rst_n), .ready(b_ready), .fail(b_fail),
    .retry_cnt(b_retry_cnt), .lock_loss_cnt(b_lock_loss_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, wanted 'h%0h", name, actual, expected);
    end
  endtask

  // Reference model: phase plus histories of synchronised lock samples.
  localparam int PH_RST = 0, PH_WAIT = 1, PH_RUN = 2, PH_FAIL = 3;
  int         ph = PH_RST;
  int         age = 0;
  bit         wait_hist[$];
  bit         run_hist[$];
  bit [1:0]   sync_q = 2'b00;
  bit [1:0]   m_mode = 2'd0;
  int         m_retry = 0;
  int         m_loss = 0;
  bit         m_err = 1'b0;
  int         ticks = 0;

  function automatic int trailing_ones();
    int n = 0;
    for (int i = wait_hist.size() - 1; i >= 0; i--) begin
      if (!wait_hist[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step();
    bit ls, acc, loss, retry_up;
    if (!rst_n) begin
      ph = PH_RST; age = 0; sync_q = 2'b00; m_mode = 2'd0;
      m_retry = 0; m_loss = 0; m_err = 1'b0;
      wait_hist.delete(); run_hist.delete();
      return;
    end
    ls       = sync_q[1];
    sync_q   = {sync_q[0], pll_lock};
    acc      = req_valid && (ph == PH_RUN || ph == PH_FAIL);
    m_err    = 1'b0;
    loss     = 1'b0;
    retry_up = 1'b0;
    case (ph)
      PH_RST: begin
        age++;
        if (age == RSTC) begin ph = PH_WAIT; wait_hist.delete(); end
      end
      PH_WAIT: begin
        if (trailing_ones() >= LS) begin
          ph = PH_RUN; run_hist.delete();
        end else if (wait_hist.size() == LT) begin
          if (m_retry == MR) ph = PH_FAIL;
          else retry_up = 1'b1;
        end else begin
          wait_hist.push_back(ls);
        end
      end
      PH_RUN: begin
        loss = !ls && (run_hist.size() > 0) && !run_hist[run_hist.size() - 1];
        run_hist.push_back(ls);
        if (run_hist.size() > 4) void'(run_hist.pop_front());
      end
      default: ;
    endcase
    if (loss && m_loss < 255) m_loss++;
    if (acc || loss || retry_up) begin
      ph = PH_RST; age = 0;
      m_retry = retry_up ? m_retry + 1 : 0;
      if (acc) m_mode = req_mode;
    end
  endtask

  task automatic tick();
    logic [20:0] got, want;
    @(posedge clk);
    model_step();
    #1;
    ticks++;
    got  = {pll_reset, pll_pwd, video_rst_n, ready, fail, req_ready, mode_err,
            mode_sel, retry_cnt, lock_loss_cnt};
    want = {ph == PH_RST, ph == PH_FAIL, ph == PH_RUN, ph == PH_RUN, ph == PH_FAIL,
            (ph == PH_RUN || ph == PH_FAIL), m_err, m_mode, 4'(m_retry), 8'(m_loss)};
    check($sformatf("model@%0d", ticks), 32'(got), 32'(want));
  endtask

  typedef struct {
    logic rn, lk, vl;
    logic [1:0] md;
    int cyc;
    logic pr, pwd, rdy, fl, rr;
    logic [3:0] rt;
    logic [7:0] ls;
    logic [1:0] ms;
  } vec_t;

  function automatic vec_t mk(input int rn, lk, vl, md, cyc, pr, pwd, rdy, fl, rr, rt, ls, ms);
    vec_t v;
    v.rn = 1'(rn); v.lk = 1'(lk); v.vl = 1'(vl); v.md = 2'(md); v.cyc = cyc;
    v.pr = 1'(pr); v.pwd = 1'(pwd); v.rdy = 1'(rdy); v.fl = 1'(fl); v.rr = 1'(rr);
    v.rt = 4'(rt); v.ls = 8'(ls); v.ms = 2'(ms);
    return v;
  endfunction

  vec_t tbl[27];

  initial begin
    //            rn lk vl md cyc  pr pwd rdy fl rr rt ls ms
    tbl[0]  = mk(0, 0, 0, 0, 3,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 3,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 8,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 1,   0, 0, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 4,   0, 0, 1, 0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 3,   0, 0, 1, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 1, 0, 0, 13,  0, 0, 1, 0, 1, 0, 1, 0);
    tbl[10] = mk(1, 1, 1, 2, 1,   1, 0, 0, 0, 0, 0, 1, 2);
    tbl[11] = mk(1, 1, 0, 0, 13,  0, 0, 1, 0, 1, 0, 1, 2);
    tbl[12] = mk(1, 0, 0, 0, 3,   0, 0, 1, 0, 1, 0, 1, 2);
    tbl[13] = mk(1, 1, 1, 3, 1,   1, 0, 0, 0, 0, 0, 2, 3);
    tbl[14] = mk(1, 1, 0, 0, 13,  0, 0, 1, 0, 1, 0, 2, 3);
    tbl[15] = mk(1, 0, 0, 0, 3,   0, 0, 1, 0, 1, 0, 2, 3);
    tbl[16] = mk(1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 3, 3);
    tbl[17] = mk(1, 0, 0, 0, 4,   0, 0, 0, 0, 0, 0, 3, 3);
    tbl[18] = mk(1, 0, 0, 0, 33,  1, 0, 0, 0, 0, 1, 3, 3);
    tbl[19] = mk(1, 0, 0, 0, 37,  1, 0, 0, 0, 0, 2, 3, 3);
    tbl[20] = mk(1, 0, 0, 0, 37,  0, 1, 0, 1, 1, 2, 3, 3);
    tbl[21] = mk(1, 1, 1, 1, 1,   1, 0, 0, 0, 0, 0, 3, 1);
    tbl[22] = mk(1, 1, 0, 0, 13,  0, 0, 1, 0, 1, 0, 3, 1);
    tbl[23] = mk(1, 0, 0, 0, 4,   1, 0, 0, 0, 0, 0, 4, 1);
    tbl[24] = mk(1, 0, 0, 0, 6,   0, 0, 0, 0, 0, 0, 4, 1);
    tbl[25] = mk(0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 1, 0, 0, 13,  0, 0, 1, 0, 1, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      rst_n = tbl[i].rn; pll_lock = tbl[i].lk; req_valid = tbl[i].vl; req_mode = tbl[i].md;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        tick();
        if (tbl[i].vl) req_valid = 1'b0;
      end
      check($sformatf("vec%0d.pll_reset", i), 32'(pll_reset), 32'(tbl[i].pr));
      check($sformatf("vec%0d.pll_pwd", i), 32'(pll_pwd), 32'(tbl[i].pwd));
      check($sformatf("vec%0d.ready", i), 32'(ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d.video_rst_n", i), 32'(video_rst_n), 32'(tbl[i].rdy));
      check($sformatf("vec%0d.fail", i), 32'(fail), 32'(tbl[i].fl));
      check($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].rr));
      check($sformatf("vec%0d.retry_cnt", i), 32'(retry_cnt), 32'(tbl[i].rt));
      check($sformatf("vec%0d.lock_loss_cnt", i), 32'(lock_loss_cnt), 32'(tbl[i].ls));
      check($sformatf("vec%0d.mode_sel", i), 32'(mode_sel), 32'(tbl[i].ms));
    end

    // Out-of-range request on the five-mode instance, then a legal one.
    check("m5.ready_before", 32'(b_ready), 32'd1);
    req_valid2 = 1'b1; req_mode2 = 3'd5;
    tick();
    req_valid2 = 1'b0;
    check("m5.err_pulse", 32'(b_mode_err), 32'd1);
    check("m5.err_ready", 32'(b_ready), 32'd1);
    check("m5.err_mode", 32'(b_mode_sel), 32'd0);
    check("m5.err_pll_reset", 32'(b_pll_reset), 32'd0);
    tick();
    check("m5.err_clear", 32'(b_mode_err), 32'd0);
    check("m5.err_ready_after", 32'(b_ready), 32'd1);
    req_valid2 = 1'b1; req_mode2 = 3'd4;
    tick();
    req_valid2 = 1'b0;
    check("m5.take_mode", 32'(b_mode_sel), 32'd4);
    check("m5.take_pll_reset", 32'(b_pll_reset), 32'd1);
    check("m5.take_ready", 32'(b_ready), 32'd0);
    check("m5.take_err", 32'(b_mode_err), 32'd0);
    for (int c = 0; c < 13; c++) tick();
    check("m5.relock_ready", 32'(b_ready), 32'd1);
    check("m5.relock_mode", 32'(b_mode_sel), 32'd4);

    // Random lock segments, requests and occasional resets against the model.
    while (ticks < 4500) begin
      int seg;
      pll_lock = ($urandom_range(0, 2) != 0);
      seg = $urandom_range(1, 60);
      for (int c = 0; c < seg; c++) begin
        if ($urandom_range(0, 3) == 0 && seg < 4) pll_lock = ~pll_lock;
        req_valid = ($urandom_range(0, 24) == 0);
        req_mode  = 2'($urandom_range(0, 3));
        rst_n     = ($urandom_range(0, 399) != 0);
        tick();
      end
    end
    rst_n = 1'b1; req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
